// File: rtl/fifo_packer_if.sv
// Handshake bundle for the packer: a narrow beat stream in, a packed wide
// word stream out (the out side feeds a FIFO write port directly).
interface fifo_packer_if #(
  parameter int IN_WIDTH = 3,
  parameter int RATIO    = 4
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO) + 1;

  // Narrow input beat stream
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;

  // Packed output word stream
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     out_count;

  // Environment side: produces beats, consumes words.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fifo_packer.sv
// Width adapter: gathers RATIO narrow beats into one wide word and presents it
// on a valid/ready port. A beat flagged last closes a partially filled word;
// lanes that were never written read as zero.
module fifo_packer #(
  parameter int IN_WIDTH  = 3,
  parameter int RATIO     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic          i_clock,
  input  logic          i_nreset,
  fifo_packer_if.slave  bus
);

  localparam int IDX_W = $clog2(RATIO);
  localparam int CNT_W = $clog2(RATIO) + 1;

  typedef logic [RATIO-1:0][IN_WIDTH-1:0] word_t;

  typedef enum logic {
    FILL = 1'b0,  // accumulating beats, no word presented
    HOLD = 1'b1   // packed word presented downstream
  } state_t;

  state_t           state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  word_t            acc_q,    acc_d;
  word_t            data_q,   data_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Scratch values built in the next-state process
  logic [IDX_W-1:0] lane;
  logic [IDX_W-1:0] first_lane;
  word_t            merged;
  word_t            fresh;
  logic             closes;

  logic in_fire;
  logic out_fire;

  // Handshake: the input is open whenever the output slot is empty or is
  // being drained this cycle, so a full word never blocks the stream.
  assign bus.out_valid = (state_q == HOLD);
  assign bus.in_ready  = ~bus.out_valid | bus.out_ready;
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Next-state, lane placement and word formation.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that left
    // one unassigned would make synthesis infer a latch to remember it.
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    count_d = count_q;

    if (LSB_FIRST != 0) begin
      lane       = idx_q;
      first_lane = '0;
    end else begin
      lane       = IDX_W'(RATIO - 1) - idx_q;
      first_lane = IDX_W'(RATIO - 1);
    end

    // Current accumulator with the incoming beat dropped into its lane.
    merged       = acc_q;
    merged[lane] = bus.in_data;

    // A zeroed accumulator holding only the incoming beat as its first lane.
    fresh             = '0;
    fresh[first_lane] = bus.in_data;

    closes = (idx_q == IDX_W'(RATIO - 1)) | bus.in_last;

    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          if (closes) begin
            // Word complete (or flushed by last): move it out, restart.
            state_d = HOLD;
            data_d  = merged;
            count_d = CNT_W'(idx_q) + CNT_W'(1);
            idx_d   = '0;
            acc_d   = '0;
          end else begin
            acc_d = merged;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      HOLD: begin
        // While the word waits, in_ready is low, so in_fire implies out_fire.
        if (out_fire) begin
          if (in_fire && bus.in_last) begin
            // Single-beat word replaces the departing one back-to-back.
            state_d = HOLD;
            data_d  = fresh;
            count_d = CNT_W'(1);
            idx_d   = '0;
            acc_d   = '0;
          end else if (in_fire) begin
            state_d = FILL;
            data_d  = '0;
            count_d = '0;
            idx_d   = IDX_W'(1);
            acc_d   = fresh;
          end else begin
            state_d = FILL;
            data_d  = '0;
            count_d = '0;
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // State, lane index, accumulator and output word registers.
  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q <= FILL;
      idx_q   <= '0;
      // NOTE: the accumulator and output word are datapath, but they are reset
      // anyway: unfilled lanes of a partial word must read as zero, and data
      // held when reset hits must not leak into the next word.
      acc_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer: two instances (lane order LSB-first and MSB-first)
// share one stimulus. Directed vector table, hand-written multi-cycle
// sequences, then random traffic checked against a queue-based model.
module tb_fifo_packer;

  localparam int IW = 3;
  localparam int R  = 4;

  logic clock = 1'b0;
  logic nreset;

  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fifo_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus_a ();
  fifo_packer_if #(.IN_WIDTH(IW), .RATIO(R)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;

  fifo_packer #(.IN_WIDTH(IW), .RATIO(R), .LSB_FIRST(1)) dut_a (
    .i_clock  (clock),
    .i_nreset (nreset),
    .bus      (bus_a)
  );

  fifo_packer #(.IN_WIDTH(IW), .RATIO(R), .LSB_FIRST(0)) dut_b (
    .i_clock  (clock),
    .i_nreset (nreset),
    .bus      (bus_b)
  );

  typedef struct {
    logic          v;
    logic [IW-1:0] d;
    logic          l;
    logic          r;
    logic          ev;   // expected out_valid after the edge
    logic [11:0]   ea;   // expected word, LSB-first instance
    logic [11:0]   eb;   // expected word, MSB-first instance
    logic [2:0]    ec;   // expected count
    logic          eir;  // expected in_ready after the edge
  } vec_t;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [2:0]  c;
  } word_exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] d, input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
  endtask

  // Word built from n beats: beat k goes to lane k (or lane R-1-k).
  function automatic logic [11:0] pack(input logic [IW-1:0] b[R], input int n, input bit msb_first);
    logic [11:0] w;
    int lane;
    w = '0;
    for (int k = 0; k < n; k++) begin
      lane = msb_first ? (R - 1 - k) : k;
      w = w | (12'(b[k]) << (IW * lane));
    end
    return w;
  endfunction

  task automatic check_word(input string name, input logic v, input logic [11:0] a,
                            input logic [11:0] b, input logic [2:0] c);
    check({name, ".valid"}, bus_a.out_valid, v);
    check({name, ".valid_b"}, bus_b.out_valid, v);
    check({name, ".data_lsb"}, bus_a.out_data, a);
    check({name, ".data_msb"}, bus_b.out_data, b);
    check({name, ".count"}, bus_a.out_count, c);
    check({name, ".count_b"}, bus_b.out_count, c);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    nreset = 1'b1;
  endtask

  vec_t             vecs[19];
  logic [IW-1:0]    beats[R];
  logic [IW-1:0]    part[R];
  int               n_part;
  word_exp_t        words[$];
  word_exp_t        we;
  logic             exp_ready;
  logic             in_fire;
  logic             out_fire;

  initial begin
    //         v  d     l  r   ev ea       eb       ec    eir
    vecs[0]  = '{1, 3'd1, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[1]  = '{1, 3'd2, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[2]  = '{1, 3'd3, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[3]  = '{1, 3'd4, 0, 1,  1, 12'h8D1, 12'h29C, 3'd4, 1};
    vecs[4]  = '{0, 3'd0, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[5]  = '{1, 3'd5, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[6]  = '{1, 3'd6, 1, 0,  1, 12'h035, 12'hB80, 3'd2, 0};
    vecs[7]  = '{1, 3'd7, 0, 0,  1, 12'h035, 12'hB80, 3'd2, 0};
    vecs[8]  = '{1, 3'd7, 0, 0,  1, 12'h035, 12'hB80, 3'd2, 0};
    vecs[9]  = '{1, 3'd7, 0, 0,  1, 12'h035, 12'hB80, 3'd2, 0};
    vecs[10] = '{0, 3'd0, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[11] = '{1, 3'd7, 1, 1,  1, 12'h007, 12'hE00, 3'd1, 1};
    vecs[12] = '{1, 3'd2, 1, 1,  1, 12'h002, 12'h400, 3'd1, 1};
    vecs[13] = '{1, 3'd3, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[14] = '{1, 3'd1, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[15] = '{1, 3'd5, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[16] = '{1, 3'd6, 1, 1,  1, 12'hD4B, 12'h66E, 3'd4, 1};
    vecs[17] = '{0, 3'd0, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};
    vecs[18] = '{0, 3'd0, 0, 1,  0, 12'h000, 12'h000, 3'd0, 1};

    // ---- Reset state
    do_reset();
    check_word("reset", 1'b0, 12'h000, 12'h000, 3'd0);
    check("reset.in_ready", bus_a.in_ready, 1'b1);

    // ---- Directed vector table
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      tick();
      check_word($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].eb, vecs[i].ec);
      check($sformatf("vec%0d.in_ready", i), bus_a.in_ready, vecs[i].eir);
    end

    // ---- Continuous stream 0..7, ready held high: two words, no bubbles
    for (int c = 0; c < 8; c++) beats[c % R] = IW'(c);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, IW'(c), 1'b0, 1'b1);
      #1;
      check($sformatf("stream%0d.in_ready", c), bus_a.in_ready, 1'b1);
      tick();
      if (c % R == R - 1) begin
        for (int k = 0; k < R; k++) beats[k] = IW'(c - R + 1 + k);
        check_word($sformatf("stream%0d", c), 1'b1, pack(beats, R, 1'b0), pack(beats, R, 1'b1), 3'd4);
      end else begin
        check($sformatf("stream%0d.valid", c), bus_a.out_valid, 1'b0);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();

    // ---- Reset mid-fill discards the partial word
    drive(1'b1, 3'd6, 1'b0, 1'b1);
    tick();
    drive(1'b1, 3'd7, 1'b0, 1'b1);
    tick();
    #2 nreset = 1'b0;
    #1;
    check_word("rst_fill", 1'b0, 12'h000, 12'h000, 3'd0);
    check("rst_fill.in_ready", bus_a.in_ready, 1'b1);
    tick();
    nreset = 1'b1;
    for (int k = 0; k < R; k++) begin
      beats[k] = IW'(k + 1);
      drive(1'b1, beats[k], 1'b0, 1'b1);
      tick();
    end
    check_word("after_rst", 1'b1, pack(beats, R, 1'b0), pack(beats, R, 1'b1), 3'd4);

    // ---- Reset mid-hold drops the held word
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    check("hold.valid", bus_a.out_valid, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check_word("rst_hold", 1'b0, 12'h000, 12'h000, 3'd0);
    tick();
    nreset = 1'b1;

    // ---- Random traffic against the queue model
    n_part = 0;
    words.delete();
    for (int k = 0; k < R; k++) part[k] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive($urandom_range(0, 3) != 0, IW'($urandom_range(0, 7)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
      #1;
      exp_ready = (words.size() == 0) || out_ready;
      check("rand.in_ready", bus_a.in_ready, exp_ready);
      check("rand.in_ready_b", bus_b.in_ready, exp_ready);
      out_fire = (words.size() != 0) && out_ready;
      in_fire  = in_valid && exp_ready;
      if (out_fire) void'(words.pop_front());
      if (in_fire) begin
        part[n_part] = in_data;
        n_part++;
        if (n_part == R || in_last) begin
          we.a = pack(part, n_part, 1'b0);
          we.b = pack(part, n_part, 1'b1);
          we.c = 3'(n_part);
          words.push_back(we);
          n_part = 0;
        end
      end
      tick();
      if (words.size() != 0)
        check_word("rand", 1'b1, words[0].a, words[0].b, words[0].c);
      else
        check_word("rand", 1'b0, 12'h000, 12'h000, 3'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
